reg_piso_tx_handshake: RTL and testbench

- Parallel-in/serial-out transmitter; the unloading end of the team's parallel-load registers.
- Captures a WIDTH-bit word through a valid/ready handshake, then shifts it out one bit per clock with a qualifier and an end-of-frame pulse.
- Sits between a parallel register bank and a single-wire serial link. It feeds the matching serial-in/parallel-out receiver.

---
 rtl/reg_piso_tx_handshake.sv | 100 ++++++++++
 tb/tb_reg_piso_tx_handshake.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/reg_piso_tx_handshake.sv
// Parallel-in/serial-out transmitter: accepts a word on a valid/ready handshake and
// shifts it out one bit per clock with a frame qualifier and an end-of-frame pulse.
module reg_piso_tx_handshake #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             reloj,
    input  logic             despeje_reset,
    input  logic [WIDTH-1:0] In,
    input  logic             carga_valida,
    output logic             listo,
    output logic             serie,
    output logic             serie_valida,
    output logic             fin
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             load;
    logic             out_bit;

    assign last    = (cnt == LAST);
    assign out_bit = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    // listo is decoded from registered state only, so the handshake adds no
    // combinational path from carga_valida to any output.
    assign load    = carga_valida & listo;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge reloj) begin
        if (despeje_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (carga_valida) state_nxt = SHIFT;
            SHIFT:   if (last && !carga_valida) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        listo        = 1'b0;
        serie        = 1'b0;
        serie_valida = 1'b0;
        fin          = 1'b0;
        case (state)
            IDLE: begin
                listo = 1'b1;
            end
            SHIFT: begin
                serie_valida = 1'b1;
                serie        = out_bit;
                fin          = last;
                listo        = last;
            end
            default: begin
                listo = 1'b0;
            end
        endcase
    end

    // Shift register and bit counter; a load on the closing edge of a frame
    // restarts the counter so the next frame follows with no gap.
    always_ff @(posedge reloj) begin
        if (despeje_reset) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= In;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            if (MSB_FIRST) begin
                sreg <= {sreg[WIDTH-2:0], 1'b0};
            end else begin
                sreg <= {1'b0, sreg[WIDTH-1:1]};
            end
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_reg_piso_tx_handshake.sv
// Bench for reg_piso_tx_handshake: LSB-first and MSB-first instances share stimulus and
// are checked every cycle against a queue-of-pending-bits model plus literal frame checks.
module tb_reg_piso_tx_handshake;

    localparam int WIDTH = 4;

    logic             reloj;
    logic             despeje_reset;
    logic [WIDTH-1:0] In;
    logic             carga_valida;
    logic             listo0, serie0, serie_valida0, fin0;
    logic             listo1, serie1, serie_valida1, fin1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model: the bits still to be presented, front = bit on the wire this cycle.
    bit q0[$];
    bit q1[$];
    bit accept;

    reg_piso_tx_handshake #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .reloj(reloj), .despeje_reset(despeje_reset), .In(In), .carga_valida(carga_valida),
        .listo(listo0), .serie(serie0), .serie_valida(serie_valida0), .fin(fin0)
    );

    reg_piso_tx_handshake #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
        .reloj(reloj), .despeje_reset(despeje_reset), .In(In), .carga_valida(carga_valida),
        .listo(listo1), .serie(serie1), .serie_valida(serie_valida1), .fin(fin1)
    );

    initial begin
        reloj = 1'b0;
        forever #5 reloj = ~reloj;
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // A word is accepted when nothing or only the last bit remains pending.
    always @(posedge reloj) begin
        if (despeje_reset) begin
            q0.delete();
            q1.delete();
        end else begin
            accept = carga_valida && (q0.size() <= 1);
            if (q0.size() > 0) begin
                q0.delete(0);
                q1.delete(0);
            end
            if (accept) begin
                for (int i = 0; i < WIDTH; i++) begin
                    q0.push_back(In[i]);
                    q1.push_back(In[WIDTH-1-i]);
                end
            end
        end
    end

    always @(negedge reloj) begin
        if (chk_en) begin
            check("model_listo_lsb", listo0, q0.size() <= 1);
            check("model_valid_lsb", serie_valida0, q0.size() > 0);
            check("model_fin_lsb", fin0, q0.size() == 1);
            check("model_serie_lsb", serie0, (q0.size() > 0) ? q0[0] : 1'b0);
            check("model_listo_msb", listo1, q1.size() <= 1);
            check("model_valid_msb", serie_valida1, q1.size() > 0);
            check("model_fin_msb", fin1, q1.size() == 1);
            check("model_serie_msb", serie1, (q1.size() > 0) ? q1[0] : 1'b0);
        end
    end

    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    task automatic cyc_check(input string tag, input logic e0, input logic e1,
                             input logic ev, input logic ef, input logic el);
        check({tag, "_serie_lsb"}, serie0, e0);
        check({tag, "_serie_msb"}, serie1, e1);
        check({tag, "_valid"}, serie_valida0 & serie_valida1, ev);
        check({tag, "_fin"}, fin0 | fin1, ef);
        check({tag, "_listo"}, listo0 & listo1, el);
    endtask

    task automatic idle_check(input string tag);
        cyc_check(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    logic [7:0] e0;
    logic [7:0] e1;

    initial begin
        despeje_reset = 1'b1;
        carga_valida  = 1'b0;
        In            = '0;
        tick();
        tick();
        despeje_reset = 1'b0;
        chk_en        = 1'b1;
        idle_check("reset");

        // Single frame, both bit orders.
        In = 4'b1011; carga_valida = 1'b1;
        tick();
        carga_valida = 1'b0; In = 4'b0000;
        e0 = 8'b0000_1011; e1 = 8'b0000_1101;
        for (int k = 0; k < 4; k++) begin
            cyc_check("single", e0[k], e1[k], 1'b1, k == 3, k == 3);
            tick();
        end
        idle_check("single_after");

        // Back-to-back frames with carga_valida held through the fin cycle.
        In = 4'b1011; carga_valida = 1'b1;
        tick();
        e0 = 8'b0110_1011; e1 = 8'b0110_1101;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) In = 4'b0110;
            if (k == 4) carga_valida = 1'b0;
            cyc_check("b2b", e0[k], e1[k], 1'b1, (k % 4) == 3, (k % 4) == 3);
            tick();
        end
        idle_check("b2b_after");

        // Load requests and In changes while busy are ignored.
        In = 4'b1011; carga_valida = 1'b1;
        tick();
        In = 4'b1111;
        e0 = 8'b0000_1011; e1 = 8'b0000_1101;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin carga_valida = 1'b0; In = 4'b0000; end
            cyc_check("busy", e0[k], e1[k], 1'b1, k == 3, k == 3);
            tick();
        end
        idle_check("busy_after");

        // Reset asserted during the cycle presenting bit 2.
        In = 4'b1011; carga_valida = 1'b1;
        tick();
        carga_valida = 1'b0;
        tick();
        tick();
        cyc_check("abort_bit2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        despeje_reset = 1'b1;
        tick();
        despeje_reset = 1'b0;
        idle_check("abort_after");
        In = 4'b0001; carga_valida = 1'b1;
        tick();
        carga_valida = 1'b0;
        e0 = 8'b0000_0001; e1 = 8'b0000_1000;
        for (int k = 0; k < 4; k++) begin
            cyc_check("post_abort", e0[k], e1[k], 1'b1, k == 3, k == 3);
            tick();
        end
        idle_check("post_abort_after");

        // Reset wins over a simultaneous load.
        despeje_reset = 1'b1; carga_valida = 1'b1; In = 4'b1011;
        tick();
        despeje_reset = 1'b0; carga_valida = 1'b0;
        idle_check("rst_vs_load");
        tick();
        idle_check("rst_vs_load_next");

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            despeje_reset = ($urandom_range(0, 59) == 0);
            carga_valida  = ($urandom_range(0, 2) != 0);
            In            = WIDTH'($urandom);
            tick();
        end
        despeje_reset = 1'b0;
        carga_valida  = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        idle_check("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
